// File: rtl/hazard_sb.sv
`timescale 1ns/1ps
// Scoreboard hazard unit: per-register pending bits for long-latency writers, pipeline stall/flush and forwarding selects.
// Optional HAZARD_PERF_EN adds the stall_cyc cycle counter port.
module hazard_sb #(
  parameter int REG_AW   = 5,
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = $clog2(MAX_PEND+1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              rs_en_d,
  input  logic              rt_en_d,
  input  logic [REG_AW-1:0] dst_d,
  input  logic              we_d,
  input  logic              long_d,
  input  logic              branch_d,
  input  logic [REG_AW-1:0] dst_e,
  input  logic              we_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] dst_m,
  input  logic              we_m,
  input  logic              memtoreg_m,
  input  logic [REG_AW-1:0] dst_w,
  input  logic              we_w,
  input  logic              done_v,
  input  logic [REG_AW-1:0] done_reg,
  input  logic              inst_stall,
  input  logic              data_stall,
  input  logic              ex_busy,
  input  logic              except_m,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              longest_stall,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              sb_err
`ifdef HAZARD_PERF_EN
  ,output logic [31:0]      stall_cyc
`endif
);
  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]   pend, pendNxt;
  logic [REG_AW-1:0] rsE, rtE;
  logic              sbHit, loadUse, brHaz, capFull, depStall, otherStall;
  logic              issue, doneOk;

  // Enabled, nonzero source matching a given destination under a qualifier.
  function automatic logic srcHit(input logic en, input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] dst, input logic qual);
    return en & qual & (src != '0) & (src == dst);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (src != '0 && we_m && src == dst_m)      return 2'b10;
    else if (src != '0 && we_w && src == dst_w) return 2'b01;
    else                                        return 2'b00;
  endfunction

  assign longest_stall = inst_stall | data_stall | ex_busy;
  assign sbHit   = (rs_en_d & (rs_d != '0) & pend[rs_d]) | (rt_en_d & (rt_d != '0) & pend[rt_d]);
  assign loadUse = srcHit(rs_en_d, rs_d, dst_e, memtoreg_e & we_e) | srcHit(rt_en_d, rt_d, dst_e, memtoreg_e & we_e);
  assign brHaz   = branch_d & (srcHit(rs_en_d, rs_d, dst_e, we_e) | srcHit(rs_en_d, rs_d, dst_m, memtoreg_m) |
                               srcHit(rt_en_d, rt_d, dst_e, we_e) | srcHit(rt_en_d, rt_d, dst_m, memtoreg_m));
  assign capFull = long_d & we_d & (pend_cnt == CNT_W'(MAX_PEND));
  assign depStall   = sbHit | loadUse | brHaz | capFull;
  assign otherStall = valid_d & depStall & ~except_m;

  assign stall_d = longest_stall | otherStall;
  assign stall_f = stall_d;
  assign stall_e = longest_stall;
  assign stall_m = longest_stall;
  assign stall_w = longest_stall;
  assign flush_d = except_m;
  assign flush_e = (otherStall & ~longest_stall) | except_m;
  assign flush_m = except_m;

  assign fwd_a_d = (rs_d != '0) & (rs_d == dst_m) & we_m & ~memtoreg_m;
  assign fwd_b_d = (rt_d != '0) & (rt_d == dst_m) & we_m & ~memtoreg_m;
  assign fwd_a_e = fwdSel(rsE);
  assign fwd_b_e = fwdSel(rtE);

  assign issue  = valid_d & ~stall_d & ~flush_d & we_d & long_d & (dst_d != '0);
  assign doneOk = done_v & pend[done_reg];

  // Set is applied after clear so a same-cycle reissue keeps the bit; exception wipes everything.
  always_comb begin
    pendNxt = pend;
    if (doneOk) pendNxt[done_reg] = 1'b0;
    if (issue)  pendNxt[dst_d]    = 1'b1;
    if (except_m) pendNxt = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend     <= '0;
      pend_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      pend     <= pendNxt;
      pend_cnt <= except_m ? '0 : pend_cnt + CNT_W'(issue) - CNT_W'(doneOk);
      sb_err   <= sb_err | (done_v & ~pend[done_reg]);
    end
  end

  // E-stage source registers, tracked here because only D sources arrive as ports.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsE <= '0;
      rtE <= '0;
    end else if (flush_e) begin
      rsE <= '0;
      rtE <= '0;
    end else if (!stall_e) begin
      rsE <= valid_d ? rs_d : '0;
      rtE <= valid_d ? rt_d : '0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 stall_cyc <= '0;
    else if (stall_d & ~flush_d) stall_cyc <= stall_cyc + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_sb.sv
`timescale 1ns/1ps
// Bench for hazard_sb: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an array-based scoreboard model.
module tb_hazard_sb;
  localparam int REG_AW = 5, MAX_PEND = 4, CNT_W = 3, NREG = 32;

  logic clk = 1'b0, resetn = 1'b0;
  logic valid_d, rs_en_d, rt_en_d, we_d, long_d, branch_d, we_e, memtoreg_e, we_m, memtoreg_m, we_w;
  logic done_v, inst_stall, data_stall, ex_busy, except_m;
  logic [REG_AW-1:0] rs_d, rt_d, dst_d, dst_e, dst_m, dst_w, done_reg;
  logic stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m, fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic longest_stall, sb_err;
  logic [CNT_W-1:0] pend_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cyc;
`endif

  hazard_sb #(.REG_AW(REG_AW), .MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .rs_en_d(rs_en_d), .rt_en_d(rt_en_d), .dst_d(dst_d), .we_d(we_d), .long_d(long_d),
    .branch_d(branch_d), .dst_e(dst_e), .we_e(we_e), .memtoreg_e(memtoreg_e),
    .dst_m(dst_m), .we_m(we_m), .memtoreg_m(memtoreg_m), .dst_w(dst_w), .we_w(we_w),
    .done_v(done_v), .done_reg(done_reg), .inst_stall(inst_stall), .data_stall(data_stall),
    .ex_busy(ex_busy), .except_m(except_m), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w), .flush_d(flush_d),
    .flush_e(flush_e), .flush_m(flush_m), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .longest_stall(longest_stall),
    .pend_cnt(pend_cnt), .sb_err(sb_err)
`ifdef HAZARD_PERF_EN
    , .stall_cyc(stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set as an array of flags, plain integer counter.
  bit mPend[NREG];
  int mCnt, mRsE, mRtE;
  bit mErr;
  int unsigned mPerf;

  bit eLong, eOther, eStallD, eFlushE, eIssue, eClr, eDep;
  int eFae, eFbe;

  function automatic bit uses(bit en, int src, int dst, bit qual);
    return en && qual && src != 0 && src == dst;
  endfunction

  function automatic int fwdE(int src);
    if (src != 0 && we_m && src == int'(dst_m)) return 2;
    if (src != 0 && we_w && src == int'(dst_w)) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      foreach (mPend[i]) mPend[i] = 0;
      mCnt = 0; mErr = 0; mRsE = 0; mRtE = 0; mPerf = 0;
    end
    eLong = inst_stall || data_stall || ex_busy;
    eDep = (rs_en_d && rs_d != 0 && mPend[rs_d]) || (rt_en_d && rt_d != 0 && mPend[rt_d]);
    eDep = eDep || uses(rs_en_d, rs_d, dst_e, we_e && memtoreg_e) || uses(rt_en_d, rt_d, dst_e, we_e && memtoreg_e);
    eDep = eDep || (branch_d && (uses(rs_en_d, rs_d, dst_e, we_e) || uses(rt_en_d, rt_d, dst_e, we_e) ||
                                 uses(rs_en_d, rs_d, dst_m, memtoreg_m) || uses(rt_en_d, rt_d, dst_m, memtoreg_m)));
    eDep = eDep || (long_d && we_d && mCnt == MAX_PEND);
    eOther  = valid_d && eDep && !except_m;
    eStallD = eLong || eOther;
    eFlushE = (eOther && !eLong) || except_m;
    eFae = fwdE(mRsE);
    eFbe = fwdE(mRtE);
    chk("outs", {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m,
                 fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, longest_stall},
        {eStallD, eStallD, eLong, eLong, eLong, except_m, eFlushE, except_m,
         rs_d != 0 && rs_d == dst_m && we_m && !memtoreg_m,
         rt_d != 0 && rt_d == dst_m && we_m && !memtoreg_m,
         2'(eFae), 2'(eFbe), eLong});
    chk("pend_cnt", pend_cnt, mCnt);
    chk("sb_err", sb_err, mErr);
`ifdef HAZARD_PERF_EN
    chk("stall_cyc", stall_cyc, mPerf);
`endif
    if (resetn) begin
      eIssue = valid_d && !eStallD && !except_m && we_d && long_d && dst_d != 0;
      eClr = done_v && mPend[done_reg];
      if (done_v && !mPend[done_reg]) mErr = 1;
      if (eStallD && !except_m) mPerf++;
      if (except_m) begin
        foreach (mPend[i]) mPend[i] = 0;
        mCnt = 0;
      end else begin
        if (eClr) mPend[done_reg] = 0;
        if (eIssue) mPend[dst_d] = 1;
        mCnt = mCnt + int'(eIssue) - int'(eClr);
      end
      if (eFlushE) begin mRsE = 0; mRtE = 0; end
      else if (!eLong) begin mRsE = valid_d ? int'(rs_d) : 0; mRtE = valid_d ? int'(rt_d) : 0; end
    end
  end

  task automatic idle();
    valid_d = 0; rs_d = 0; rt_d = 0; rs_en_d = 0; rt_en_d = 0; dst_d = 0; we_d = 0; long_d = 0;
    branch_d = 0; dst_e = 0; we_e = 0; memtoreg_e = 0; dst_m = 0; we_m = 0; memtoreg_m = 0;
    dst_w = 0; we_w = 0; done_v = 0; done_reg = 0; inst_stall = 0; data_stall = 0; ex_busy = 0;
    except_m = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic longWr(input int r);
    idle(); valid_d = 1; dst_d = REG_AW'(r); we_d = 1; long_d = 1;
  endtask

  function automatic logic [REG_AW-1:0] pickReg();
    return REG_AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7));
  endfunction

  task automatic randIn();
    int cand[$];
    valid_d = ($urandom_range(0, 9) != 0);
    rs_d = pickReg(); rt_d = pickReg(); rs_en_d = $urandom_range(0, 1); rt_en_d = $urandom_range(0, 1);
    dst_d = pickReg(); we_d = ($urandom_range(0, 9) < 7); long_d = ($urandom_range(0, 9) < 3);
    branch_d = ($urandom_range(0, 99) < 15);
    dst_e = pickReg(); we_e = $urandom_range(0, 1); memtoreg_e = ($urandom_range(0, 4) == 0);
    dst_m = pickReg(); we_m = $urandom_range(0, 1); memtoreg_m = ($urandom_range(0, 4) == 0);
    dst_w = pickReg(); we_w = $urandom_range(0, 1);
    inst_stall = ($urandom_range(0, 19) == 0); data_stall = ($urandom_range(0, 19) == 0);
    ex_busy = ($urandom_range(0, 19) == 0); except_m = ($urandom_range(0, 49) == 0);
    done_v = 0; done_reg = 0;
    foreach (mPend[i]) if (mPend[i]) cand.push_back(i);
    if (!except_m && cand.size() > 0 && $urandom_range(0, 3) == 0) begin
      done_v = 1; done_reg = REG_AW'(cand[$urandom_range(0, cand.size()-1)]);
    end else if (!except_m && $urandom_range(0, 199) == 0) begin
      done_v = 1; done_reg = pickReg();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    #1 chk("rst_cnt", pend_cnt, 0); chk("rst_err", sb_err, 0); chk("rst_stall", stall_d, 0);

    // Load-use on $5
    cyc(); idle(); valid_d = 1; rs_d = 5; rs_en_d = 1; dst_e = 5; we_e = 1; memtoreg_e = 1;
    #1 chk("lu_stall", stall_d, 1); chk("lu_flush_e", flush_e, 1);
    cyc(); idle(); valid_d = 1; rs_d = 5; rs_en_d = 1; dst_m = 5; we_m = 1; memtoreg_m = 1;
    #1 chk("lu_release", {stall_d, flush_e}, 0);
    cyc(); idle(); dst_m = 5; we_m = 1;
    #1 chk("lu_fwd_e", fwd_a_e, 2'b10);

    // Divide to $8, consumer waits until the cycle after done
    cyc(); longWr(8);
    #1 chk("div_issue", stall_d, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(); idle(); valid_d = 1; rs_d = 8; rs_en_d = 1;
      if (i == 5) begin done_v = 1; done_reg = 8; end
      #1 chk("div_stall", stall_d, 1); chk("div_cnt1", pend_cnt, 1);
    end
    cyc(); idle(); valid_d = 1; rs_d = 8; rs_en_d = 1;
    #1 chk("div_release", stall_d, 0); chk("div_cnt0", pend_cnt, 0);

    // Capacity
    for (int r = 1; r <= 4; r++) begin
      cyc(); longWr(r);
      #1 chk("cap_fill", stall_d, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); longWr(5);
      if (i == 2) begin done_v = 1; done_reg = 1; end
      #1 chk("cap_stall", stall_d, 1); chk("cap_cnt4", pend_cnt, 4);
    end
    cyc(); longWr(5);
    #1 chk("cap_go", stall_d, 0); chk("cap_cnt3", pend_cnt, 3);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle(); done_v = 1; done_reg = REG_AW'(k + 2);
      #1 chk("cap_drain", pend_cnt, 4 - k);
    end
    cyc(); idle();
    #1 chk("cap_empty", pend_cnt, 0);

    // Same-cycle issue and done on $9
    cyc(); longWr(9);
    cyc(); longWr(9); done_v = 1; done_reg = 9;
    #1 chk("same_nostall", stall_d, 0); chk("same_cnt", pend_cnt, 1);
    cyc(); idle(); valid_d = 1; rt_d = 9; rt_en_d = 1;
    #1 chk("same_pend9", stall_d, 1); chk("same_cnt_hold", pend_cnt, 1);
    cyc(); idle(); done_v = 1; done_reg = 9;
    cyc(); idle(); done_v = 1; done_reg = 0;
    #1 chk("err_before", sb_err, 0); chk("err_cnt0", pend_cnt, 0);
    cyc(); idle();
    #1 chk("err_r0", sb_err, 1);
    resetn = 0;
    #1 chk("err_async_reset", sb_err, 0);
    cyc(); resetn = 1; done_v = 1; done_reg = 12;
    cyc(); idle();
    #1 chk("err_r12", sb_err, 1);

    // Exception with three pending writers
    for (int r = 1; r <= 3; r++) begin cyc(); longWr(r); end
    cyc(); idle(); valid_d = 1; rs_d = 1; rs_en_d = 1; except_m = 1;
    #1 chk("exc_flush", {flush_d, flush_e, flush_m}, 3'b111); chk("exc_mask", stall_d, 0);
    chk("exc_cnt3", pend_cnt, 3);
    cyc(); idle(); valid_d = 1; rs_d = 1; rs_en_d = 1;
    #1 chk("exc_cnt0", pend_cnt, 0); chk("exc_free", stall_d, 0);

`ifdef HAZARD_PERF_EN
    cyc(); idle(); resetn = 0;
    cyc(); resetn = 1; ex_busy = 1;
    repeat (10) cyc();
    idle();
    #1 chk("perf_10", stall_cyc, 10);
`endif

    for (int n = 0; n < 3000; n++) begin
      cyc(); randIn();
      if (n == 1500) resetn = 0;
      if (n == 1502) resetn = 1;
    end
    cyc(); idle();
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
